pc_sequencer_multi_cycle: RTL

Fetch/next-PC controller for the multi-cycle CPU variant. It owns the program counter and sequences each instruction through an instruction-memory fetch handshake and a wait-for-execute phase. It then selects the next PC from sequential, branch, jump, register-jump or exception sources. It replaces the bare clocked PC register used in the single-cycle core and drives the instruction memory address directly.

---
 rtl/pc_sequencer_multi_cycle.sv | 133 +++++++++++++
 1 files changed

// File: rtl/pc_sequencer_multi_cycle.sv
// pc_sequencer_multi_cycle
// Fetch/next-PC controller for the multi-cycle CPU. Owns the program counter,
// runs the instruction-memory fetch handshake, waits for the datapath to
// finish, then selects the next PC (exception > jr > jmp > branch > pc+4).
// Optional feature macro: PCSEQ_INSTRET_EN builds the retired-instruction
// counter; without it instret is tied to zero.
module pc_sequencer_multi_cycle #(
    parameter logic [31:0] RESET_PC   = 32'h0000_0000,
    parameter logic [31:0] EXC_VECTOR = 32'h0000_0080
) (
    input  logic        clk,
    input  logic        rst_n,
    output logic        imem_req,
    output logic [31:0] imem_addr,
    input  logic        imem_ack,
    input  logic [31:0] imem_rdata,
    output logic [31:0] ir,
    output logic        ir_valid,
    input  logic        exec_done,
    input  logic        br_taken,
    input  logic [31:0] br_offset,
    input  logic        jmp,
    input  logic [25:0] jmp_target,
    input  logic        jr,
    input  logic [31:0] jr_addr,
    input  logic        exc,
    output logic [31:0] pc,
    output logic [31:0] epc,
    output logic [31:0] instret
);

    typedef enum logic [1:0] {
        ST_RESET,
        ST_FETCH,
        ST_EXEC
    } state_t;

    state_t      state;
    logic [31:0] pc_plus4;
    logic [31:0] br_target;
    logic [31:0] jmp_addr;
    logic [31:0] next_pc;
    logic        take_exc;

    assign imem_addr = pc;

    // Next-PC selection; a misaligned register-jump target becomes an exception.
    always_comb begin
        pc_plus4  = pc + 32'd4;
        br_target = pc_plus4 + (br_offset << 2);
        jmp_addr  = {pc_plus4[31:28], jmp_target, 2'b00};
        take_exc  = 1'b0;
        next_pc   = pc_plus4;
        if (exc) begin
            take_exc = 1'b1;
        end else if (jr) begin
            if (jr_addr[1:0] != 2'b00) begin
                take_exc = 1'b1;
            end else begin
                next_pc = jr_addr;
            end
        end else if (jmp) begin
            next_pc = jmp_addr;
        end else if (br_taken) begin
            next_pc = br_target;
        end
        if (take_exc) begin
            next_pc = EXC_VECTOR;
        end
    end

    // Sequencer FSM with registered PC, EPC, instruction register and handshake outputs.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state    <= ST_RESET;
            pc       <= RESET_PC;
            epc      <= 32'd0;
            ir       <= 32'd0;
            ir_valid <= 1'b0;
            imem_req <= 1'b0;
        end else begin
            ir_valid <= 1'b0;
            case (state)
                ST_RESET: begin
                    state    <= ST_FETCH;
                    imem_req <= 1'b1;
                end
                ST_FETCH: begin
                    if (imem_ack) begin
                        if (exc) begin
                            epc      <= pc;
                            pc       <= EXC_VECTOR;
                            imem_req <= 1'b1;
                        end else begin
                            ir       <= imem_rdata;
                            ir_valid <= 1'b1;
                            imem_req <= 1'b0;
                            state    <= ST_EXEC;
                        end
                    end
                end
                ST_EXEC: begin
                    if (exec_done) begin
                        pc       <= next_pc;
                        imem_req <= 1'b1;
                        state    <= ST_FETCH;
                        if (take_exc) begin
                            epc <= pc;
                        end
                    end
                end
                default: begin
                    state    <= ST_RESET;
                    imem_req <= 1'b0;
                end
            endcase
        end
    end

`ifdef PCSEQ_INSTRET_EN
    // Count every instruction completed in EXEC, faulting ones included.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            instret <= 32'd0;
        end else if (state == ST_EXEC && exec_done) begin
            instret <= instret + 32'd1;
        end
    end
`else
    assign instret = 32'd0;
`endif

endmodule
